// File: rtl/bridge_pkg.sv
// Shared types and constants for the UART-to-PSRAM command bridge.
package bridge_pkg;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;

    localparam logic [1:0] RW_WRITE = 2'd1;
    localparam logic [1:0] RW_READ  = 2'd2;

    localparam logic [DATA_W-1:0] DEF_ACK_WORD = 16'h4F4B;
    localparam logic [DATA_W-1:0] DEF_ERR_WORD = 16'h4552;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // One queued command: {we, addr, wdata}
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Only write and read commands are accepted into the queue
    function automatic logic rw_valid(input logic [1:0] rw);
        return (rw == RW_WRITE) || (rw == RW_READ);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO with registered count and full/empty flags.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    // Occupancy after this edge
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Pointers, count and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage, not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_psram_bridge.sv
// Queues UART commands, issues them to the PSRAM controller and paces responses to the UART transmitter.
module uart_psram_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TX_GAP_CYCLES  = 5000,
    parameter logic [15:0] ACK_WORD       = DEF_ACK_WORD,
    parameter logic [15:0] ERR_WORD       = DEF_ERR_WORD
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        quad_start,
    input  logic [1:0]  read_write,
    input  logic [22:0] address,
    input  logic [15:0] data_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        send_uart,
    output logic [15:0] send_msg,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned GAP_W  = $clog2(TX_GAP_CYCLES) + 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [22:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_msg;
    logic              r_send;
    logic              r_busy;
    logic              r_ovf;
    logic              r_tmo_err;
    logic [TMO_W-1:0]  r_tmo;
    logic [GAP_W-1:0]  r_gap;

    state_t            w_state_nxt;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [22:0]       w_addr_nxt;
    logic [15:0]       w_wdata_nxt;
    logic [15:0]       w_msg_nxt;
    logic              w_send_nxt;
    logic              w_tmo_err_nxt;
    logic [TMO_W-1:0]  w_tmo_nxt;
    logic              w_gap_load;

    logic              w_cmd_valid;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    cmd_t              w_push_cmd;
    cmd_t              w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_cnt;
    logic [FCNT_W-1:0] w_fifo_cnt_nxt;

    // Push decision: fullness is judged on the registered flag, so a same-cycle pop never frees a slot
    assign w_cmd_valid = quad_start && rw_valid(read_write);
    assign w_push      = w_cmd_valid && !w_fifo_full;
    assign w_drop      = w_cmd_valid && w_fifo_full;

    // Pack the incoming command
    always_comb begin
        w_push_cmd.we    = (read_write == RW_WRITE);
        w_push_cmd.addr  = address;
        w_push_cmd.wdata = data_in;
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    // FIFO occupancy after this edge, used to register busy without a cycle of lag
    always_comb begin
        w_fifo_cnt_nxt = w_fifo_cnt;
        if (w_push && !w_pop) begin
            w_fifo_cnt_nxt = w_fifo_cnt + FCNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_fifo_cnt_nxt = w_fifo_cnt - FCNT_W'(1);
        end
    end

    // Next-state and registered-output logic of the sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_msg_nxt     = r_msg;
        w_send_nxt    = 1'b0;
        w_tmo_err_nxt = r_tmo_err;
        w_tmo_nxt     = r_tmo;
        w_gap_load    = 1'b0;
        w_pop         = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_we_nxt    = w_head.we;
                    w_addr_nxt  = w_head.addr;
                    w_wdata_nxt = w_head.wdata;
                    w_req_nxt   = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // Ack is checked first so it wins over a coincident timeout
                if (mem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_msg_nxt   = r_we ? ACK_WORD : mem_rdata;
                    w_state_nxt = RESP;
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_req_nxt     = 1'b0;
                    w_msg_nxt     = ERR_WORD;
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = RESP;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            RESP: begin
                if (r_gap == '0) begin
                    w_send_nxt  = 1'b1;
                    w_gap_load  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_msg     <= '0;
            r_send    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_tmo     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_msg     <= w_msg_nxt;
            r_send    <= w_send_nxt;
            r_tmo_err <= w_tmo_err_nxt;
            r_tmo     <= w_tmo_nxt;
            r_busy    <= (w_fifo_cnt_nxt != '0) || (w_state_nxt != IDLE);
        end
    end

    // Sticky overflow flag for dropped commands
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // Transmit spacing counter, free-running down to zero
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_gap <= '0;
        end else if (w_gap_load) begin
            r_gap <= GAP_W'(TX_GAP_CYCLES);
        end else if (r_gap != '0) begin
            r_gap <= r_gap - GAP_W'(1);
        end
    end

    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign send_uart   = r_send;
    assign send_msg    = r_msg;
    assign busy        = r_busy;
    assign overflow    = r_ovf;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_uart_psram_bridge.sv
// Self-checking bench for uart_psram_bridge: vector table plus multi-cycle corner sequences.
module tb_uart_psram_bridge;

    localparam int TX_GAP = 5000;

    logic        sys_clk    = 1'b0;
    logic        rst        = 1'b1;
    logic        quad_start = 1'b0;
    logic [1:0]  read_write = 2'd0;
    logic [22:0] address    = '0;
    logic [15:0] data_in    = '0;
    logic        mem_ack    = 1'b0;
    logic [15:0] mem_rdata  = '0;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        send_uart;
    logic [15:0] send_msg;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_sends  = 0;
    int t_last   = -100000;
    logic [15:0] q_msg[$];

    typedef struct {
        logic [1:0]  rw;
        logic [22:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        int          dly;
        logic        exp_we;
        logic [15:0] exp_msg;
    } vec_t;

    vec_t vt[4];

    uart_psram_bridge dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .quad_start  (quad_start),
        .read_write  (read_write),
        .address     (address),
        .data_in     (data_in),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .send_uart   (send_uart),
        .send_msg    (send_msg),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Response log, recorded on the edge after each pulse
    always @(posedge sys_clk) begin
        if (send_uart === 1'b1) begin
            n_sends <= n_sends + 1;
            q_msg.push_back(send_msg);
        end
    end

    initial begin
        repeat (95000) @(posedge sys_clk);
        $display("FAIL watchdog: simulation exceeded 95000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [1:0] rw, input logic [22:0] a, input logic [15:0] d);
        quad_start = 1'b1;
        read_write = rw;
        address    = a;
        data_in    = d;
        step();
        quad_start = 1'b0;
        read_write = 2'd0;
    endtask

    task automatic wait_req(input int budget, output int t);
        int k = 0;
        while (mem_req !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("mem_req_seen", 32'(mem_req), 32'd1);
        t = cyc;
    endtask

    task automatic wait_send(input int budget, output int t);
        int k = 0;
        while (send_uart !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("send_uart_seen", 32'(send_uart), 32'd1);
        t = cyc;
        t_last = cyc;
    endtask

    task automatic wait_gap();
        while (cyc < t_last + TX_GAP + 2) step();
    endtask

    task automatic ack(input logic [15:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    initial begin
        int t0, t1, t2, r2, hi, base, saw;

        vt[0] = '{rw: 2'd1, addr: 23'h000010, data: 16'hBEEF, rdata: 16'h0000, dly: 3, exp_we: 1'b1, exp_msg: 16'h4F4B};
        vt[1] = '{rw: 2'd2, addr: 23'h7FFFFF, data: 16'h0000, rdata: 16'h1234, dly: 1, exp_we: 1'b0, exp_msg: 16'h1234};
        vt[2] = '{rw: 2'd1, addr: 23'h000000, data: 16'h0000, rdata: 16'hFFFF, dly: 0, exp_we: 1'b1, exp_msg: 16'h4F4B};
        vt[3] = '{rw: 2'd2, addr: 23'h2AAAAA, data: 16'h5555, rdata: 16'hA5C3, dly: 7, exp_we: 1'b0, exp_msg: 16'hA5C3};

        // Reset state
        repeat (3) step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_send_uart", 32'(send_uart), 32'd0);
        chk("rst_send_msg", 32'(send_msg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step();

        // Single-command vectors with exact latency
        for (int i = 0; i < 4; i++) begin
            wait_gap();
            issue(vt[i].rw, vt[i].addr, vt[i].data);
            chk("vec_req_c1", 32'(mem_req), 32'd0);
            chk("vec_busy_c1", 32'(busy), 32'd1);
            step();
            chk("vec_req_c2", 32'(mem_req), 32'd1);
            chk("vec_we", 32'(mem_we), 32'(vt[i].exp_we));
            chk("vec_addr", 32'(mem_addr), 32'(vt[i].addr));
            chk("vec_wdata", 32'(mem_wdata), 32'(vt[i].data));
            repeat (vt[i].dly) step();
            chk("vec_req_at_ack", 32'(mem_req), 32'd1);
            ack(vt[i].rdata);
            chk("vec_req_dropped", 32'(mem_req), 32'd0);
            chk("vec_send_early", 32'(send_uart), 32'd0);
            step();
            chk("vec_send_ack2", 32'(send_uart), 32'd1);
            chk("vec_msg", 32'(send_msg), 32'(vt[i].exp_msg));
            t_last = cyc;
            step();
            chk("vec_send_one_cycle", 32'(send_uart), 32'd0);
            chk("vec_msg_held", 32'(send_msg), 32'(vt[i].exp_msg));
            chk("vec_busy_done", 32'(busy), 32'd0);
        end

        // Overflow: six commands, one in flight plus four queued, sixth dropped
        wait_gap();
        q_msg.delete();
        base = n_sends;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("ovf_before", 32'(overflow), 32'd0);
            issue(2'd2, 23'(100 + i), 16'(i));
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_req(6000, t0);
            chk("ovf_order_addr", 32'(mem_addr), 32'(100 + i));
            chk("ovf_we", 32'(mem_we), 32'd0);
            repeat (2) step();
            ack(16'hC000 + 16'(i));
        end
        wait_send(6000, t0);
        step();
        step();
        chk("ovf_busy_end", 32'(busy), 32'd0);
        chk("ovf_resp_count", 32'(n_sends - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < q_msg.size()) chk("ovf_resp_order", 32'(q_msg[i]), 32'hC000 + 32'(i));
        end

        // Timeout: request held for exactly TIMEOUT_CYCLES cycles
        issue(2'd1, 23'h000055, 16'h1111);
        step();
        hi = 0;
        while (mem_req === 1'b1 && hi < 2000) begin
            hi++;
            step();
        end
        chk("tmo_req_cycles", 32'(hi), 32'd1024);
        chk("tmo_err_flag", 32'(timeout_err), 32'd1);
        wait_send(6000, t0);
        chk("tmo_msg", 32'(send_msg), 32'h4552);
        issue(2'd2, 23'h000066, 16'h0000);
        wait_req(10, t0);
        chk("tmo_next_addr", 32'(mem_addr), 32'h66);
        ack(16'h0BAD);
        wait_send(6000, t0);
        chk("tmo_next_msg", 32'(send_msg), 32'h0BAD);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Ack in the very cycle the timeout would fire: ack wins
        issue(2'd2, 23'h000077, 16'h0000);
        step();
        repeat (1023) step();
        chk("tie_req_high", 32'(mem_req), 32'd1);
        ack(16'h0ACE);
        wait_send(6000, t0);
        chk("tie_msg", 32'(send_msg), 32'h0ACE);

        // Gap: second command issued while first response is still being sent
        wait_gap();
        issue(2'd2, 23'h000200, 16'h0000);
        issue(2'd2, 23'h000201, 16'h0000);
        chk("gap_req1", 32'(mem_req), 32'd1);
        chk("gap_addr1", 32'(mem_addr), 32'h200);
        t0 = cyc;
        ack(16'hD001);
        wait_send(10, t1);
        chk("gap_send1_lat", 32'(t1 - t0), 32'd2);
        chk("gap_msg1", 32'(send_msg), 32'hD001);
        wait_req(20, r2);
        chk("gap_addr2", 32'(mem_addr), 32'h201);
        chk("gap_req2_early", 32'(r2 < t1 + TX_GAP), 32'd1);
        while (cyc < t0 + 10) step();
        chk("gap_req2_at_ack", 32'(mem_req), 32'd1);
        ack(16'hD002);
        wait_send(6000, t2);
        chk("gap_spacing_min", 32'((t2 - t1) >= TX_GAP), 32'd1);
        chk("gap_spacing_max", 32'((t2 - t1) <= TX_GAP + 1), 32'd1);
        chk("gap_msg2", 32'(send_msg), 32'hD002);

        // Reset while in REQ (gap counter still running), then invalid commands
        issue(2'd1, 23'h000300, 16'hCAFE);
        wait_req(10, t0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_mem_req", 32'(mem_req), 32'd0);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mrst_send_msg", 32'(send_msg), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_overflow", 32'(overflow), 32'd0);
        chk("mrst_timeout_err", 32'(timeout_err), 32'd0);
        base = n_sends;
        saw = 0;
        quad_start = 1'b1;
        read_write = 2'd0;
        address    = 23'h000400;
        step();
        read_write = 2'd3;
        step();
        quad_start = 1'b0;
        read_write = 2'd0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) mem_ack = 1'b1;
            if (mem_req === 1'b1 || send_uart === 1'b1) saw++;
            step();
            mem_ack = 1'b0;
        end
        chk("inv_no_activity", 32'(saw), 32'd0);
        chk("inv_busy", 32'(busy), 32'd0);
        chk("inv_no_send", 32'(n_sends - base), 32'd0);

        // After reset the gap counter is clear: response at ack+2
        issue(2'd2, 23'h012345, 16'h0000);
        step();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        ack(16'h7777);
        step();
        chk("post_rst_send", 32'(send_uart), 32'd1);
        chk("post_rst_msg", 32'(send_msg), 32'h7777);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_psram_bridge.md
Name: uart_psram_bridge

Overview:
Command sequencer between the UART command receiver and the PSRAM controller. Queues decoded read/write commands in a small FIFO and issues each one to the PSRAM controller through a req/ack handshake. After each command it returns one 16-bit response word to the UART transmitter: the read data, an ACK word, or an error word. It enforces a minimum spacing between transmit requests so that no response is overwritten while the UART transmitter is still busy.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
TIMEOUT_CYCLES, 1024, sys_clk cycles allowed from mem_req rise to mem_ack before abort
TX_GAP_CYCLES, 5000, minimum sys_clk cycles between send_uart pulses (covers 2 bytes at 115200 baud plus transmitter debounce)
ACK_WORD, 16'h4F4B, response word for a completed write ("OK")
ERR_WORD, 16'h4552, response word for a timeout ("ER")

Ports:
sys_clk  in  1  system clock, 27 MHz
rst  in  1  synchronous reset, active-high
quad_start  in  1  one-cycle command strobe from the UART receiver
read_write  in  2  command type: 1 = write, 2 = read, 0/3 = invalid
address  in  23  PSRAM word address
data_in  in  16  write data
mem_req  out  1  request to the PSRAM controller
mem_we  out  1  1 = write, 0 = read
mem_addr  out  23  request address
mem_wdata  out  16  request write data
mem_ack  in  1  one-cycle completion; on reads, mem_rdata is valid in the same cycle
mem_rdata  in  16  read data
send_uart  out  1  one-cycle transmit request to the UART
send_msg  out  16  response word; byte [15:8] is sent first
busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE
overflow  out  1  sticky: a command was dropped because the FIFO was full
timeout_err  out  1  sticky: at least one command timed out

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, gap counter 0. Reset has priority over every other event.
- Reset mid-transaction: mem_req drops on the next edge and the in-flight command is abandoned. The PSRAM controller must tolerate a dropped request.
- Push rule: on quad_start with read_write ∈ {1,2}, push {we, address, data_in}. Invalid read_write is ignored; nothing is pushed and no response is sent.
- FIFO full: the push is dropped and overflow is set. This holds even if a pop occurs in the same cycle; fullness is evaluated before the edge.
- Empty FIFO with a simultaneous push: there is no bypass; the entry becomes visible on the next cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and load mem_we/mem_addr/mem_wdata; go to REQ.
  - REQ: mem_req=1, with we/addr/wdata held stable. The timeout counter increments each cycle.
    - On mem_ack: deassert mem_req on the next edge. send_msg ← mem_rdata for a read, ACK_WORD for a write. Go to RESP.
    - If the counter reaches TIMEOUT_CYCLES: deassert mem_req, send_msg ← ERR_WORD, set timeout_err, go to RESP.
  - RESP: wait until the gap counter is 0. Then pulse send_uart for exactly one cycle, load the gap counter with TX_GAP_CYCLES, and go to IDLE.
- send_msg holds its value until the next response is loaded.
- The gap counter decrements to 0 independently of the FSM, so the FSM can issue the next PSRAM command while the previous response is still being transmitted.
- Latency: with an empty FIFO, the FSM in IDLE and the gap counter at 0:
  - quad_start at cycle 0 → FIFO entry at cycle 1 → mem_req high at cycle 2.
  - mem_ack at cycle N → send_uart high at cycle N+2.
- mem_ack while not in REQ is ignored.
- mem_ack in the same cycle the timeout fires: the ack wins, and a normal response is sent.
- Counter widths are $clog2 of the respective parameter + 1. No wrap-around is permitted.

Decomposition:
- Shared package `bridge_pkg`:
  - FSM state encoding: IDLE, REQ, RESP.
  - RW_WRITE = 2'd1, RW_READ = 2'd2.
  - Command entry width = 40 bits: {we, addr[22:0], wdata[15:0]}.
  - Default ACK_WORD and ERR_WORD values.
- One sub-module, `cmd_fifo`: synchronous FIFO, width 40, depth FIFO_DEPTH, with push/pop/full/empty and a registered count.

Test Plan:
1. Write: quad_start with rw=1, addr=23'h000010, data=16'hBEEF; mem_ack 3 cycles after mem_req → mem_we=1, mem_addr=23'h10, mem_wdata=16'hBEEF; send_uart pulses once with send_msg=16'h4F4B.
2. Read: rw=2, addr=23'h7FFFFF; mem_ack with mem_rdata=16'h1234 → mem_we=0; send_msg=16'h1234 and send_uart pulses at ack+2.
3. Overflow: hold mem_ack low, issue 6 valid commands → 1 command in REQ plus 4 in the FIFO; the 6th is dropped and overflow=1. After acks, exactly 5 responses are sent, in order.
4. Timeout: no mem_ack → mem_req falls after 1024 cycles; send_msg=16'h4552; timeout_err=1. The next command proceeds normally.
5. Gap: two reads acked 10 cycles apart → send_uart pulses are ≥5000 cycles apart; the second mem_req is issued before the first gap expires.
6. Reset while in REQ, plus an invalid command → mem_req=0 one cycle after rst; all outputs 0; no send_uart. A subsequent quad_start with rw=0 produces no mem_req and no send_uart.
